// File: rtl/ysyx_25030093_idu_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25030093_idu_stage_if
//  Description : Fetch-side and execute-side handshake bundle of the decode
//                stage. The master modport is the surrounding pipeline, the
//                slave modport is the decode stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_25030093_idu_stage_if #(
    parameter int XLEN = 32
);
    // fetch -> decode
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    // decode -> execute
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [31:0]     out_imm;
    logic [3:0]      out_class;
    logic            out_illegal;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_rd, out_rs1,
               out_rs2, out_funct3, out_funct7, out_imm, out_class, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_rd, out_rs1,
               out_rs2, out_funct3, out_funct7, out_imm, out_class, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_25030093_idu_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25030093_idu_stage
//  Description : RV32I/RV32E decode stage. Decodes the incoming word
//                combinationally and stores the decoded record in a 2-entry
//                FIFO skid buffer that feeds the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25030093_idu_stage #(
    parameter int RV32E = 1,
    parameter int XLEN  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    ysyx_25030093_idu_stage_if.slave        bus
);
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_system = 7'b1110011;

    localparam logic [3:0] c_cls_lui     = 4'd0;
    localparam logic [3:0] c_cls_auipc   = 4'd1;
    localparam logic [3:0] c_cls_jal     = 4'd2;
    localparam logic [3:0] c_cls_jalr    = 4'd3;
    localparam logic [3:0] c_cls_branch  = 4'd4;
    localparam logic [3:0] c_cls_load    = 4'd5;
    localparam logic [3:0] c_cls_store   = 4'd6;
    localparam logic [3:0] c_cls_opimm   = 4'd7;
    localparam logic [3:0] c_cls_op      = 4'd8;
    localparam logic [3:0] c_cls_system  = 4'd9;
    localparam logic [3:0] c_cls_unknown = 4'd15;

    logic [31:0] w_inst;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_imm;
    logic [3:0]  w_cls;
    logic        w_use_rd, w_use_rs1, w_use_rs2;
    logic        w_bad_reg, w_ill;

    logic [XLEN-1:0] r_pc   [0:1];
    logic [31:0]     r_inst [0:1];
    logic [31:0]     r_imm  [0:1];
    logic [3:0]      r_cls  [0:1];
    logic            r_ill  [0:1];
    logic [1:0]      r_count;
    logic            r_wr_ptr, r_rd_ptr;

    logic w_in_ready, w_out_valid, w_push, w_pop;
    logic [31:0] w_head_inst;

    assign w_inst  = bus.in_inst;
    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    // Opcode decode: class, immediate format and which register fields are live
    always_comb begin
        w_cls     = c_cls_unknown;
        w_imm     = 32'd0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_inst[6:0])
            c_op_lui:    begin w_cls = c_cls_lui;    w_imm = w_imm_u; w_use_rd = 1'b1; end
            c_op_auipc:  begin w_cls = c_cls_auipc;  w_imm = w_imm_u; w_use_rd = 1'b1; end
            c_op_jal:    begin w_cls = c_cls_jal;    w_imm = w_imm_j; w_use_rd = 1'b1; end
            c_op_jalr:   begin w_cls = c_cls_jalr;   w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
            c_op_branch: begin w_cls = c_cls_branch; w_imm = w_imm_b; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            c_op_load:   begin w_cls = c_cls_load;   w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
            c_op_store:  begin w_cls = c_cls_store;  w_imm = w_imm_s; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            c_op_opimm:  begin w_cls = c_cls_opimm;  w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
            c_op_op:     begin w_cls = c_cls_op;     w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            c_op_system: begin w_cls = c_cls_system; w_imm = w_imm_i; w_use_rd = 1'b1; end
            default:     begin w_cls = c_cls_unknown; end
        endcase
    end

    // On RV32E only x0..x15 exist, so bit 4 of a live register field is illegal
    assign w_bad_reg = (RV32E != 0) &&
                       ((w_use_rd  && w_inst[11]) ||
                        (w_use_rs1 && w_inst[19]) ||
                        (w_use_rs2 && w_inst[24]));
    assign w_ill     = (w_cls == c_cls_unknown) || (w_inst[1:0] != 2'b11) || w_bad_reg;

    // Ready depends only on registered occupancy plus rst/flush, never on out_ready
    assign w_in_ready  = !rst && !flush && (r_count < 2'd2);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Occupancy and pointers; flush and reset discard everything and win over push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Record storage, written at the accept edge into the tail slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= 32'd0;
                r_imm[i]  <= 32'd0;
                r_cls[i]  <= 4'd0;
                r_ill[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_pc[r_wr_ptr]   <= bus.in_pc;
            r_inst[r_wr_ptr] <= w_inst;
            r_imm[r_wr_ptr]  <= w_imm;
            r_cls[r_wr_ptr]  <= w_cls;
            r_ill[r_wr_ptr]  <= w_ill;
        end
    end

    // Head entry is presented only while valid so idle outputs read zero
    assign w_head_inst     = w_out_valid ? r_inst[r_rd_ptr] : 32'd0;
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_pc      = w_out_valid ? r_pc[r_rd_ptr]  : '0;
    assign bus.out_inst    = w_head_inst;
    assign bus.out_rd      = w_head_inst[11:7];
    assign bus.out_rs1     = w_head_inst[19:15];
    assign bus.out_rs2     = w_head_inst[24:20];
    assign bus.out_funct3  = w_head_inst[14:12];
    assign bus.out_funct7  = w_head_inst[31:25];
    assign bus.out_imm     = w_out_valid ? r_imm[r_rd_ptr] : 32'd0;
    assign bus.out_class   = w_out_valid ? r_cls[r_rd_ptr] : 4'd0;
    assign bus.out_illegal = w_out_valid && r_ill[r_rd_ptr];

endmodule
`default_nettype wire

// File: doc/ysyx_25030093_idu_stage.md
Name: ysyx_25030093_idu_stage

Overview:
Decode stage sitting directly downstream of the instruction fetch stage. It accepts {pc, inst} over a valid/ready handshake and decodes RV32I/RV32E fields and the sign-extended immediate. Results are held in a 2-entry FIFO skid buffer and presented to the execute stage over a second valid/ready handshake. A flush input discards buffered work on redirect.

Parameters:
RV32E, 1, 1 = register indices above 15 flag out_illegal; 0 = full RV32I register file
XLEN, 32, data/pc width; only 32 supported

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  discard all buffered entries
in_valid  in  1  fetch stage presents an instruction
in_ready  out  1  stage can accept an instruction this cycle
in_pc  in  32  pc of in_inst
in_inst  in  32  raw instruction word
out_valid  out  1  decoded entry available
out_ready  in  1  execute stage accepts the entry
out_pc  out  32  pc of the head entry
out_inst  out  32  raw word of the head entry
out_rd  out  5  inst[11:7]
out_rs1  out  5  inst[19:15]
out_rs2  out  5  inst[24:20]
out_funct3  out  3  inst[14:12]
out_funct7  out  7  inst[31:25]
out_imm  out  32  sign-extended immediate
out_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 9 SYSTEM, 15 unknown
out_illegal  out  1  head entry is illegal

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high. On reset: count=0, rd/wr pointers=0, out_valid=0, in_ready=0 during the reset cycle; all out_* data ports read 0.
- Storage: 2-entry FIFO of decoded records {pc, inst, rd, rs1, rs2, funct3, funct7, imm, class, illegal}. Decode is combinational on in_inst; the record is written at the accept edge.
- Accept: in_valid && in_ready at a rising edge. in_ready = !rst && !flush && (count < 2); it depends on registered state only, with no combinational path from out_ready.
- Pop: out_valid && out_ready at a rising edge. out_valid = (count != 0). out_* always show the head entry and are stable while out_valid=1 and out_ready=0.
- Latency: an instruction accepted at edge N appears on out_* after edge N (same cycle as the registered count update), i.e. one cycle input-to-output.
- Simultaneous push and pop with count=1: count stays 1, head advances, new entry becomes the tail. With count=2, in_ready=0, so push is impossible. No bypass when empty.
- Ordering: strict FIFO; pointers are 1 bit each and wrap 1->0.
- Flush: at the edge where flush=1, count and pointers clear to 0; any concurrent input and the head pop are dropped. out_valid=0 on the next cycle. Flush has priority over push and pop.
- Reset mid-operation: all entries are discarded, same as flush.
- Immediates:
  - I-type (JALR, LOAD, OPIMM, SYSTEM): sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: {inst[31:12], 12'b0}.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - OP and unknown: 0.
- Class decode: from inst[6:0]. 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OPIMM, 0110011 OP, 1110011 SYSTEM; anything else is class 15.
- out_illegal is set when any of the following holds:
  - class = 15;
  - inst[1:0] != 2'b11;
  - RV32E=1 and any register field used by the class has bit 4 set.
- Registers used per class:
  - rd: all classes except BRANCH/STORE.
  - rs1: JALR, BRANCH, LOAD, STORE, OPIMM, OP.
  - rs2: BRANCH, STORE, OP.
- Illegal entries still flow through the FIFO normally.

Test Plan:
- Single push of pc=0x80000000, inst=0x00500093 with out_ready=1 -> next cycle out_valid=1, class=7, rd=1, rs1=0, imm=0x00000005, illegal=0; popped, out_valid=0 after the following edge.
- Immediate checks: 0x12345137 -> class 0, rd=2, imm=0x12345000; 0xFE000EE3 -> class 4, imm=0xFFFFFFFC; 0xFFDFF06F -> class 2, imm=0xFFFFFFFC.
- Illegal cases: 0x00000000 -> class 15, illegal=1; with RV32E=1, 0x00000833 (add x16,x0,x0) -> class 8, illegal=1; same word with RV32E=0 -> illegal=0.
- Backpressure: out_ready=0, offer 3 instructions at pc 0x0, 0x4, 0x8 -> in_ready drops after the 2nd accept and the 3rd is held. Raise out_ready -> pcs emerge 0x0, 0x4, 0x8 in order, each stable while stalled.
- Steady stream: in_valid=1 and out_ready=1 continuously for 8 words -> one pop per cycle after the first, count never exceeds 1, no drops.
- Flush with count=2 and in_valid=1 in the same cycle -> next cycle out_valid=0 and in_ready=1; the offered word is not later emitted. Repeat with rst instead of flush -> same result.
